// File: rtl/bus_transfer_ctrl_if.sv
// -----------------------------------------------------------------------------
// bus_transfer_ctrl_if
// Bundles the requester handshake and the register-bank strobes of the
// bus transfer controller.
//   req_valid / req_ready     : per-requester command handshake (bit0 = req0)
//   reqN_op/src/dst/bus       : command fields of requester N
//   reg_enable/reg_out_sel    : per-register bus drive enable and bus select
//   reg_latch/reg_in_sel      : per-register latch strobe and bus select
//   reg_inc                   : per-register increment strobe
//   busy/done/done_id/done_err: controller status and completion report
// Modports: master = requester/register side, slave = controller.
// -----------------------------------------------------------------------------
interface bus_transfer_ctrl_if #(
  parameter int NREG = 4
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic            req0_op;
  logic            req1_op;
  logic [1:0]      req0_src;
  logic [1:0]      req1_src;
  logic [1:0]      req0_dst;
  logic [1:0]      req1_dst;
  logic            req0_bus;
  logic            req1_bus;
  logic [NREG-1:0] reg_enable;
  logic [NREG-1:0] reg_out_sel;
  logic [NREG-1:0] reg_latch;
  logic [NREG-1:0] reg_in_sel;
  logic [NREG-1:0] reg_inc;
  logic            busy;
  logic            done;
  logic            done_id;
  logic            done_err;

  modport master (
    output req_valid, req0_op, req1_op, req0_src, req1_src,
           req0_dst, req1_dst, req0_bus, req1_bus,
    input  req_ready, reg_enable, reg_out_sel, reg_latch, reg_in_sel,
           reg_inc, busy, done, done_id, done_err
  );

  modport slave (
    input  req_valid, req0_op, req1_op, req0_src, req1_src,
           req0_dst, req1_dst, req0_bus, req1_bus,
    output req_ready, reg_enable, reg_out_sel, reg_latch, reg_in_sel,
           reg_inc, busy, done, done_id, done_err
  );
endinterface

// File: rtl/bus_transfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_transfer_ctrl
// Two-requester controller that sequences register-to-register MOVEs over
// one of two shared buses (BUSA/BUSB) and in-place register INCrements.
// Requesters are arbitrated round-robin; one command is in flight at a time.
// Ports:
//   clk   : single clock, all state updates on its rising edge
//   reset : synchronous, active-low
//   bif   : bus_transfer_ctrl_if.slave (handshake, command fields,
//           register strobes, busy/done status)
// -----------------------------------------------------------------------------
module bus_transfer_ctrl #(
  parameter int NREG = 4
) (
  input  logic                clk,
  input  logic                reset,
  bus_transfer_ctrl_if.slave  bif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LATCH,
    ST_INC
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            ptr;
  logic            cap_op;
  logic            cap_bus;
  logic            cap_id;
  logic            cap_err;
  logic [1:0]      cap_src;
  logic [1:0]      cap_dst;

  logic            done_q;
  logic            done_id_q;
  logic            done_err_q;

  logic [1:0]      grant;
  logic            accept;
  logic            sel_id;
  logic            sel_op;
  logic            sel_bus;
  logic [1:0]      sel_src;
  logic [1:0]      sel_dst;
  logic            sel_err;
  logic            finishing;

  logic [NREG-1:0] enable_d;
  logic [NREG-1:0] out_sel_d;
  logic [NREG-1:0] latch_d;
  logic [NREG-1:0] in_sel_d;
  logic [NREG-1:0] inc_d;

  // Round-robin grant: only offered in IDLE and never while reset is held.
  // On contention the pointer picks; a lone requester is always granted.
  always_comb begin
    grant = 2'b00;
    if (reset && (state == ST_IDLE)) begin
      if (bif.req_valid == 2'b11) begin
        grant = ptr ? 2'b10 : 2'b01;
      end else begin
        grant = bif.req_valid;
      end
    end
  end

  assign bif.req_ready = grant;
  assign accept        = |grant;
  assign sel_id        = grant[1];
  assign sel_op        = sel_id ? bif.req1_op  : bif.req0_op;
  assign sel_bus       = sel_id ? bif.req1_bus : bif.req0_bus;
  assign sel_src       = sel_id ? bif.req1_src : bif.req0_src;
  assign sel_dst       = sel_id ? bif.req1_dst : bif.req0_dst;

  // The source index only matters for MOVE; INC ignores it entirely.
  assign sel_err = ((sel_op == 1'b0) && (int'(sel_src) >= NREG)) ||
                   (int'(sel_dst) >= NREG);

  assign finishing = (state == ST_LATCH) || (state == ST_INC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = sel_op ? ST_INC : ST_DRIVE;
      ST_DRIVE: state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_IDLE;
      ST_INC:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Command capture, arbitration pointer and the completion report.
  // done is registered so it lands on the first IDLE cycle after the last
  // active state; a reset in that last state therefore suppresses it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr        <= 1'b0;
      cap_op     <= 1'b0;
      cap_bus    <= 1'b0;
      cap_id     <= 1'b0;
      cap_err    <= 1'b0;
      cap_src    <= 2'd0;
      cap_dst    <= 2'd0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q <= finishing;
      if (finishing) begin
        done_id_q  <= cap_id;
        done_err_q <= cap_err;
      end
      if (accept) begin
        ptr     <= ~sel_id;
        cap_op  <= sel_op;
        cap_bus <= sel_bus;
        cap_id  <= sel_id;
        cap_err <= sel_err;
        cap_src <= sel_src;
        cap_dst <= sel_dst;
      end
    end
  end

  // Register strobes are decoded purely from state and captured fields, so
  // they cannot glitch with the live request inputs. A command flagged as
  // out of range keeps its timing but asserts nothing.
  always_comb begin
    enable_d  = '0;
    out_sel_d = '0;
    latch_d   = '0;
    in_sel_d  = '0;
    inc_d     = '0;
    if (!cap_err) begin
      for (int i = 0; i < NREG; i++) begin
        if ((state == ST_DRIVE) || (state == ST_LATCH)) begin
          enable_d[i]  = (int'(cap_src) == i);
          out_sel_d[i] = (int'(cap_src) == i) && cap_bus;
        end
        if (state == ST_LATCH) begin
          latch_d[i]  = (int'(cap_dst) == i);
          in_sel_d[i] = (int'(cap_dst) == i) && cap_bus;
        end
        if (state == ST_INC) begin
          inc_d[i] = (int'(cap_dst) == i);
        end
      end
    end
  end

  assign bif.reg_enable  = enable_d;
  assign bif.reg_out_sel = out_sel_d;
  assign bif.reg_latch   = latch_d;
  assign bif.reg_in_sel  = in_sel_d;
  assign bif.reg_inc     = inc_d;
  assign bif.busy        = (state != ST_IDLE);
  assign bif.done        = done_q;
  assign bif.done_id     = done_id_q;
  assign bif.done_err    = done_err_q;

endmodule

// File: doc/bus_transfer_ctrl.md
BUS_TRANSFER_CTRL -- requirements
Module: bus_transfer_ctrl

Interface
REQ-001 Parameter: NREG, default 4, number of attached 8-bit bus registers (legal range 2..4).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  per-requester command valid (bit 0 = requester 0, bit 1 = requester 1).
REQ-005 req_ready  output  2  per-requester command accept; a command transfers on a cycle with valid & ready.
REQ-006 req0_op / req1_op  input  1 each  0 = MOVE, 1 = INC.
REQ-007 req0_src / req1_src  input  2 each  source register index (MOVE only).
REQ-008 req0_dst / req1_dst  input  2 each  destination register index.
REQ-009 req0_bus / req1_bus  input  1 each  bus for MOVE, 0 = BUSA, 1 = BUSB.
REQ-010 reg_enable  output  NREG  per-register bus drive enable.
REQ-011 reg_out_sel  output  NREG  per-register drive bus select (0 = BUSA, 1 = BUSB).
REQ-012 reg_latch  output  NREG  per-register latch strobe.
REQ-013 reg_in_sel  output  NREG  per-register latch bus select (0 = BUSA, 1 = BUSB).
REQ-014 reg_inc  output  NREG  per-register increment strobe.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 done_id  output  1  requester index of the completed command; valid while done is high.
REQ-018 done_err  output  1  high with done if the completed command had an index >= NREG.

Function
REQ-019 FSM states: IDLE, DRIVE, LATCH, INC; encoding is free.
REQ-020 req_ready shall be nonzero only in IDLE, have at most one bit set, and be combinational from state, req_valid and the round-robin pointer.
REQ-021 Arbitration: round-robin. If both requesters are valid, grant the requester named by the pointer. If only one is valid, grant it. After each grant, the pointer moves to the non-granted requester. Pointer reset value is 0.
REQ-022 On accept, capture op/src/dst/bus and the requester id. Requesters hold their fields stable while valid and not ready.
REQ-023 MOVE accepted in cycle t: DRIVE in t+1, LATCH in t+2, IDLE in t+3.
REQ-024 DRIVE: reg_enable[src] = 1, reg_out_sel[src] = bus; all other strobes 0.
REQ-025 LATCH: reg_enable[src] and reg_out_sel[src] as in DRIVE; reg_latch[dst] = 1, reg_in_sel[dst] = bus.
REQ-026 INC accepted in cycle t: INC in t+1 with reg_inc[dst] = 1 only; IDLE in t+2.
REQ-027 done shall be high for exactly one cycle: the first IDLE cycle after LATCH or INC. done_id equals the captured id.
REQ-028 A new command may be accepted in the same cycle done is high, giving back-to-back throughput of 3 cycles per MOVE and 2 cycles per INC.
REQ-029 At most one reg_enable bit shall be high in any cycle, so each bus has at most one driver.
REQ-030 All reg_* outputs shall be 0 in IDLE.
REQ-031 All reg_* outputs shall be registered, or decoded only from state registers, so they are glitch-free and independent of same-cycle req inputs.
REQ-032 MOVE with src == dst shall execute normally (drive and latch the same register).
REQ-033 Out-of-range index (src or dst >= NREG; src checked only for MOVE): the command is accepted and sequenced with the same timing, but no reg_* bit is asserted for that command; done_err = 1 with done.
REQ-034 req_valid deasserted while not ready: the command is dropped with no side effect.

Reset
REQ-035 While reset = 0 at a posedge, the next state shall be: state IDLE, all reg_* = 0, busy = 0, done = 0, done_id = 0, done_err = 0, pointer = 0, captured fields = 0.
REQ-036 Reset during DRIVE, LATCH or INC aborts the command: no reg_latch or reg_inc in the following cycle and no done pulse.
REQ-037 req_ready shall be 0 while reset = 0.

Verification
REQ-038 MOVE src=1 dst=3 bus=1 from req0 at t -> t+1 enable=0010, out_sel[1]=1; t+2 latch=1000, in_sel[3]=1, enable=0010; t+3 done=1, done_id=0.
REQ-039 Both requesters valid continuously with MOVEs after reset -> grants alternate 0,1,0,1, one grant every 3 cycles; done_id sequence 0,1,0,1.
REQ-040 req1 INC dst=2 -> reg_inc=0100 for exactly one cycle; done the next cycle with done_id=1; a second INC accepted in the done cycle gives done every 2 cycles.
REQ-041 NREG=3, MOVE src=0 dst=3 -> reg_latch stays 000 throughout; done=1 with done_err=1 at t+3.
REQ-042 Reset asserted in the LATCH cycle -> next cycle all reg_*=0, busy=0, done=0; after release the pointer is 0, so with both requesters valid req0 is granted first.
REQ-043 Every test: assertion that popcount(reg_enable) <= 1 and that all reg_*=0 whenever busy=0.
